// File: rtl/apb_slv_interface_gen.sv
// APB slave front end: one outstanding transfer, wait states for read latency.
// Optional macro APB_SLV_STRB_EN enables byte strobes and zero-strobe errors.
module apb_slv_interface_gen #(
    parameter int APB_AW     = 12,
    parameter int APB_DW     = 32,
    parameter int RD_LATENCY = 1,
    parameter int NUM_REGS   = 64
) (
    input  logic                  apb_pclk_i,
    input  logic                  apb_presetn_i,
    input  logic [APB_AW-1:0]     apb_paddr_i,
    input  logic                  apb_psel_i,
    input  logic                  apb_penable_i,
    input  logic                  apb_pwrite_i,
    input  logic [APB_DW-1:0]     apb_pwdata_i,
    input  logic [APB_DW/8-1:0]   apb_pstrb_i,
    output logic                  apb_pready_o,
    output logic [APB_DW-1:0]     apb_prdata_o,
    output logic                  apb_pslverr_o,
    output logic [APB_AW-1:0]     apb_reg_waddr_o,
    output logic [APB_DW-1:0]     apb_reg_wdata_o,
    output logic [APB_DW/8-1:0]   apb_reg_wstrb_o,
    output logic                  apb_reg_wrenable_o,
    output logic [APB_AW-1:0]     apb_reg_raddr_o,
    output logic                  apb_reg_rdenable_o,
    input  logic [APB_DW-1:0]     apb_reg_rdata_i,
    output logic                  apb_reg_rd_byte_complete_o
);

    localparam int SW  = APB_DW / 8;
    localparam int BSH = $clog2(SW);
    localparam logic [APB_AW:0] NREG = (APB_AW+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                write_q, write_d;
    logic [APB_AW-1:0]   addr_q, addr_d;
    logic [APB_DW-1:0]   wdata_q, wdata_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic                rdc_q, rdc_d;
    logic [APB_AW-1:0]   widx;
    logic                new_err;
    logic                strb_err;

`ifdef APB_SLV_STRB_EN
    logic [SW-1:0]       strb_q, strb_d;
    assign strb_err = apb_pwrite_i && (apb_pstrb_i == '0);
`else
    logic                unused_strb;
    assign unused_strb = ^apb_pstrb_i;
    assign strb_err    = 1'b0;
`endif

    assign widx    = apb_paddr_i >> BSH;
    assign new_err = ({1'b0, widx} >= NREG) || strb_err;

    // Next-state, latch and pulse logic for the transfer FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef APB_SLV_STRB_EN
        strb_d  = strb_q;
`endif
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        rdc_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    addr_d  = apb_paddr_i;
                    write_d = apb_pwrite_i;
                    wdata_d = apb_pwdata_i;
`ifdef APB_SLV_STRB_EN
                    strb_d  = apb_pstrb_i;
`endif
                    err_d   = new_err;
                    rden_d  = !apb_pwrite_i && !new_err;
                    if (apb_pwrite_i || new_err || RD_LATENCY == 0) begin
                        state_d = READY;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = READY;
                else             cnt_d   = cnt_q - 3'd1;
            end
            READY: begin
                if (!apb_psel_i) begin
                    state_d = IDLE;
                end else if (apb_penable_i) begin
                    state_d = IDLE;
                    wren_d  = write_q && !err_q;
                    rdc_d   = !write_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched transfer registers
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef APB_SLV_STRB_EN
            strb_q  <= '0;
`endif
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            rdc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef APB_SLV_STRB_EN
            strb_q  <= strb_d;
`endif
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            rdc_q   <= rdc_d;
        end
    end

    // APB response is only driven while the FSM sits in READY
    always_comb begin
        apb_pready_o  = (state_q == READY);
        apb_pslverr_o = (state_q == READY) && err_q;
        apb_prdata_o  = '0;
        if (state_q == READY && !write_q && !err_q)
            apb_prdata_o = apb_reg_rdata_i;
    end

    assign apb_reg_waddr_o            = addr_q;
    assign apb_reg_raddr_o            = addr_q;
    assign apb_reg_wdata_o            = wdata_q;
    assign apb_reg_wrenable_o         = wren_q;
    assign apb_reg_rdenable_o         = rden_q;
    assign apb_reg_rd_byte_complete_o = rdc_q;
`ifdef APB_SLV_STRB_EN
    assign apb_reg_wstrb_o            = strb_q;
`else
    assign apb_reg_wstrb_o            = '1;
`endif

endmodule

// File: tb/tb_apb_slv_interface_gen.sv
// Bench for apb_slv_interface_gen: directed scenarios plus random traffic
// checked against a word-array reference model of the register file.
module tb_apb_slv_interface_gen;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready_o, pslverr_o;
    logic [31:0] prdata_o;
    logic [11:0] waddr_o, raddr_o;
    logic [31:0] wdata_o, rdata_i;
    logic [3:0]  wstrb_o;
    logic        wren_o, rden_o, rdc_o;

    int nvec = 0;
    int nerr = 0;

    apb_slv_interface_gen #(
        .APB_AW(12), .APB_DW(32), .RD_LATENCY(LAT), .NUM_REGS(64)
    ) u_dut (
        .apb_pclk_i(clk),
        .apb_presetn_i(rst_n),
        .apb_paddr_i(paddr),
        .apb_psel_i(psel),
        .apb_penable_i(penable),
        .apb_pwrite_i(pwrite),
        .apb_pwdata_i(pwdata),
        .apb_pstrb_i(pstrb),
        .apb_pready_o(pready_o),
        .apb_prdata_o(prdata_o),
        .apb_pslverr_o(pslverr_o),
        .apb_reg_waddr_o(waddr_o),
        .apb_reg_wdata_o(wdata_o),
        .apb_reg_wstrb_o(wstrb_o),
        .apb_reg_wrenable_o(wren_o),
        .apb_reg_raddr_o(raddr_o),
        .apb_reg_rdenable_o(rden_o),
        .apb_reg_rdata_i(rdata_i),
        .apb_reg_rd_byte_complete_o(rdc_o)
    );

    always #5 clk = ~clk;

    // register-file stand-in and pulse monitor
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    int cyc = 0;
    int rd_age = 15;
    int wr_cnt = 0, rden_cnt = 0, rdc_cnt = 0;
    int wr_cyc = -1, rden_cyc = -1, rdc_cyc = -1;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    assign rdata_i = ((rden_o ? 0 : rd_age) >= LAT) ? mem[raddr_o[7:2]]
                                                     : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (wren_o) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = waddr_o;
            wr_data = wdata_o;
            wr_strb = wstrb_o;
            for (int b = 0; b < 4; b++)
                if (wstrb_o[b]) mem[waddr_o[7:2]][8*b +: 8] = wdata_o[8*b +: 8];
        end
        if (rden_o) begin
            rden_cnt++;
            rden_cyc = cyc;
        end
        if (rdc_o) begin
            rdc_cnt++;
            rdc_cyc = cyc;
        end
        if (rden_o) rd_age = 1;
        else if (rd_age < 15) rd_age++;
        cyc++;
    end

    // expected outcome of one transfer from the address map rules
    function automatic void model(input bit w, input logic [11:0] a,
                                  input logic [31:0] d, input logic [3:0] s,
                                  output bit e_err, output int e_lat,
                                  output logic [31:0] e_rd, output bit e_wr,
                                  output logic [3:0] e_strb);
        int idx = int'(a) / 4;
        e_err = (idx >= 64);
`ifdef APB_SLV_STRB_EN
        if (w && s == 4'h0) e_err = 1'b1;
        e_strb = s;
`else
        e_strb = 4'hF;
`endif
        e_lat = (w || e_err) ? 1 : LAT + 1;
        e_rd  = (!w && !e_err) ? exp_mem[idx] : 32'h0;
        e_wr  = w && !e_err;
        if (e_wr)
            for (int b = 0; b < 4; b++)
                if (e_strb[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic apb_xfer(input bit w, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output int t0, output int tc,
                            output logic [31:0] rd, output logic err);
        @(negedge clk);
        t0 = cyc;
        psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 20 && !pready_o; i++) @(negedge clk);
        tc  = cyc;
        rd  = prdata_o;
        err = pslverr_o;
        if (!pready_o) begin
            nvec++; nerr++;
            $display("FAIL xfer_timeout addr=%h pready=%b required=1", a, pready_o);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [3:0] ws;
`ifdef APB_SLV_STRB_EN
        ws = 4'h0;
`else
        ws = 4'hF;
`endif
        #1;
        nvec++;
        if ({pready_o, pslverr_o, prdata_o, waddr_o, wdata_o, wren_o,
             raddr_o, rden_o, rdc_o, wstrb_o} !== {2'b00, 32'h0, 12'h0,
             32'h0, 1'b0, 12'h0, 2'b00, ws}) begin
            nerr++;
            $display("FAIL reset_outputs pready=%b err=%b prdata=%h wstrb=%h wren=%b rden=%b required all 0 wstrb=%h",
                     pready_o, pslverr_o, prdata_o, wstrb_o, wren_o, rden_o, ws);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write;
        int t0, tc, el, wc;
        logic [31:0] rd, er; logic err; bit ee, ew; logic [3:0] es;
        wc = wr_cnt;
        model(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (tc - t0 !== 1 || err !== 1'b0) begin
            nerr++;
            $display("FAIL write_ready lat=%0d err=%b required lat=1 err=0", tc - t0, err);
        end
        nvec++;
        if (wr_cnt - wc !== 1 || wr_cyc !== tc + 1) begin
            nerr++;
            $display("FAIL write_pulse count=%0d cyc=%0d required count=1 cyc=%0d",
                     wr_cnt - wc, wr_cyc, tc + 1);
        end
        nvec++;
        if (wr_addr !== 12'h010 || wr_data !== 32'hA5A5_1234) begin
            nerr++;
            $display("FAIL write_latch addr=%h data=%h required 010 a5a51234", wr_addr, wr_data);
        end
    endtask

    task automatic test_read_latency;
        int t0, tc, el, rc, cc;
        logic [31:0] rd, er; logic err; bit ee, ew; logic [3:0] es;
        model(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, t0, tc, rd, err);
        idle(2);
        rc = rden_cnt; cc = rdc_cnt;
        model(1'b0, 12'h008, 32'h0, 4'h0, ee, el, er, ew, es);
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, t0, tc, rd, err);
        idle(3);
        nvec++;
        if (rden_cnt - rc !== 1 || rden_cyc !== t0 + 1) begin
            nerr++;
            $display("FAIL read_rdenable count=%0d cyc=%0d required count=1 cyc=%0d",
                     rden_cnt - rc, rden_cyc, t0 + 1);
        end
        nvec++;
        if (tc - t0 !== LAT + 1 || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
            nerr++;
            $display("FAIL read_data lat=%0d data=%h err=%b required lat=%0d data=deadbeef err=0",
                     tc - t0, rd, err, LAT + 1);
        end
        nvec++;
        if (rdc_cnt - cc !== 1 || rdc_cyc !== tc + 1) begin
            nerr++;
            $display("FAIL read_complete count=%0d cyc=%0d required count=1 cyc=%0d",
                     rdc_cnt - cc, rdc_cyc, tc + 1);
        end
    endtask

    task automatic test_range_err;
        int t0, tc, el, rc, wc, cc;
        logic [31:0] rd, er; logic err; bit ee, ew; logic [3:0] es;
        rc = rden_cnt; wc = wr_cnt; cc = rdc_cnt;
        model(1'b0, 12'h100, 32'h0, 4'h0, ee, el, er, ew, es);
        apb_xfer(1'b0, 12'h100, 32'h0, 4'h0, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (tc - t0 !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            nerr++;
            $display("FAIL range_read lat=%0d err=%b data=%h required lat=1 err=1 data=0",
                     tc - t0, err, rd);
        end
        nvec++;
        if (rden_cnt !== rc || wr_cnt !== wc || rdc_cnt - cc !== 1) begin
            nerr++;
            $display("FAIL range_pulses rden=%0d wren=%0d rdc=%0d required 0 0 1",
                     rden_cnt - rc, wr_cnt - wc, rdc_cnt - cc);
        end
        model(1'b1, 12'hFFC, 32'h1234_5678, 4'hF, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'hFFC, 32'h1234_5678, 4'hF, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (err !== 1'b1 || wr_cnt !== wc) begin
            nerr++;
            $display("FAIL range_write err=%b wren=%0d required err=1 wren=0", err, wr_cnt - wc);
        end
    endtask

    task automatic test_strobe;
        int t0, tc, el, wc;
        logic [31:0] rd, er; logic err; bit ee, ew; logic [3:0] es;
        model(1'b1, 12'h020, 32'h1122_3344, 4'b0101, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h020, 32'h1122_3344, 4'b0101, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (wr_strb !== es || wr_addr !== 12'h020) begin
            nerr++;
            $display("FAIL strobe_fwd wstrb=%h addr=%h required wstrb=%h addr=020", wr_strb, wr_addr, es);
        end
        wc = wr_cnt;
        model(1'b1, 12'h024, 32'h5566_7788, 4'b0000, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h024, 32'h5566_7788, 4'b0000, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (err !== logic'(ee) || (wr_cnt - wc) !== int'(ew)) begin
            nerr++;
            $display("FAIL strobe_zero err=%b wren=%0d required err=%b wren=%0d",
                     err, wr_cnt - wc, ee, ew);
        end
    endtask

    task automatic test_back_to_back;
        int t0a, tca, t0b, tcb, el;
        logic [31:0] rd, er, d; logic err; bit ee, ew; logic [3:0] es;
        d = $urandom;
        model(1'b1, 12'h004, d, 4'hF, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h004, d, 4'hF, t0a, tca, rd, err);
        model(1'b0, 12'h004, 32'h0, 4'h0, ee, el, er, ew, es);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, t0b, tcb, rd, err);
        idle(2);
        nvec++;
        if (t0b !== tca + 1 || tcb - t0b !== LAT + 1) begin
            nerr++;
            $display("FAIL b2b_timing setup=%0d lat=%0d required setup=%0d lat=%0d",
                     t0b, tcb - t0b, tca + 1, LAT + 1);
        end
        nvec++;
        if (rd !== d || rd !== er) begin
            nerr++;
            $display("FAIL b2b_data data=%h required %h", rd, d);
        end
    endtask

    task automatic test_idle_access;
        int wc = wr_cnt;
        bit bad = 1'b0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h030;
        repeat (3) begin
            @(negedge clk);
            if (pready_o) bad = 1'b1;
        end
        idle(2);
        nvec++;
        if (bad || wr_cnt !== wc) begin
            nerr++;
            $display("FAIL idle_access pready_seen=%b wren=%0d required 0 0", bad, wr_cnt - wc);
        end
    endtask

    task automatic test_reset_mid;
        int t0, tc, el, wc;
        logic [31:0] rd, er; logic err; bit ee, ew; logic [3:0] es;
        wc = wr_cnt;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({pready_o, pslverr_o, prdata_o, rden_o, wren_o, rdc_o, raddr_o}
            !== 49'h0) begin
            nerr++;
            $display("FAIL reset_mid pready=%b err=%b prdata=%h rden=%b raddr=%h required all 0",
                     pready_o, pslverr_o, prdata_o, rden_o, raddr_o);
        end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        model(1'b1, 12'h00C, 32'hCAFE_0001, 4'hF, ee, el, er, ew, es);
        apb_xfer(1'b1, 12'h00C, 32'hCAFE_0001, 4'hF, t0, tc, rd, err);
        model(1'b0, 12'h00C, 32'h0, 4'h0, ee, el, er, ew, es);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, t0, tc, rd, err);
        idle(2);
        nvec++;
        if (rd !== er || tc - t0 !== LAT + 1 || wr_cnt - wc !== 1) begin
            nerr++;
            $display("FAIL reset_recover data=%h lat=%0d wren=%0d required %h %0d 1",
                     rd, tc - t0, wr_cnt - wc, er, LAT + 1);
        end
    endtask

    task automatic test_random;
        int t0, tc, el, wc, rc, cc;
        logic [31:0] rd, er, d; logic err; bit ee, ew, w; logic [3:0] es, s;
        logic [11:0] a;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 12'h13F));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            wc = wr_cnt; rc = rden_cnt; cc = rdc_cnt;
            model(w, a, d, s, ee, el, er, ew, es);
            apb_xfer(w, a, d, s, t0, tc, rd, err);
            idle(2);
            nvec++;
            if (tc - t0 !== el || err !== logic'(ee) || rd !== er) begin
                nerr++;
                $display("FAIL rand_resp #%0d w=%b a=%h lat=%0d err=%b data=%h required %0d %b %h",
                         n, w, a, tc - t0, err, rd, el, ee, er);
            end
            nvec++;
            if ((wr_cnt - wc) !== int'(ew) || (rden_cnt - rc) !== int'(!w && !ee) ||
                (rdc_cnt - cc) !== int'(!w) || (ew && (wr_addr !== a ||
                wr_data !== d || wr_strb !== es))) begin
                nerr++;
                $display("FAIL rand_side #%0d wren=%0d rden=%0d rdc=%0d addr=%h data=%h strb=%h required wren=%0d addr=%h data=%h strb=%h",
                         n, wr_cnt - wc, rden_cnt - rc, rdc_cnt - cc, wr_addr,
                         wr_data, wr_strb, ew, a, d, es);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        test_reset;
        test_write;
        test_read_latency;
        test_range_err;
        test_strobe;
        test_back_to_back;
        test_idle_access;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
